// File: rtl/int_request_ctrl.sv
// int_request_ctrl: collects rising-edge interrupt events from NSRC device lines,
// holds them pending, masks and prioritizes them (lowest index wins) and issues
// one interrupt at a time to the CPU, waiting for eret before issuing the next.
// Optional build macro: INT_SYNC_EN adds a two-flop synchronizer on every irq bit.
module int_request_ctrl #(
    parameter int unsigned NSRC = 4,
    parameter int unsigned IDW  = $clog2(NSRC)
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] irq,
    input  logic            mask_we,
    input  logic [NSRC-1:0] mask_wdata,
    input  logic            eret,
    output logic            int_out,
    output logic [IDW-1:0]  int_id,
    output logic            in_service,
    output logic [NSRC-1:0] pending,
    output logic [NSRC-1:0] mask
);

    typedef enum logic [1:0] {StIdle, StReq, StServ} state_t;

    state_t          state_q, state_d;
    logic [NSRC-1:0] irq_s;
    logic [NSRC-1:0] irq_d_q;
    logic [NSRC-1:0] irq_edge;
    logic [NSRC-1:0] pending_q, pending_d;
    logic [NSRC-1:0] mask_q;
    logic [NSRC-1:0] eligible;
    logic [NSRC-1:0] clr;
    logic [IDW-1:0]  int_id_q, int_id_d;
    logic [IDW-1:0]  win_id;
    logic            int_out_q;
    logic            in_service_q;

`ifdef INT_SYNC_EN
    logic [NSRC-1:0] sync1_q, sync2_q;

    // Two-flop synchronizer for asynchronous device sources
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= irq;
            sync2_q <= sync1_q;
        end
    end

    assign irq_s = sync2_q;
`else
    assign irq_s = irq;
`endif

    assign irq_edge = irq_s & ~irq_d_q;
    assign eligible = pending_q & mask_q;

    // Fixed priority: scan downwards so the lowest eligible index is left in win_id
    always_comb begin
        win_id = '0;
        for (int i = NSRC - 1; i >= 0; i--) begin
            if (eligible[i]) win_id = IDW'(i);
        end
    end

    // Next state, winner latch and pending clear on the accepting eret
    always_comb begin
        state_d  = state_q;
        int_id_d = int_id_q;
        clr      = '0;
        unique case (state_q)
            StIdle: begin
                if (|eligible) begin
                    state_d  = StReq;
                    int_id_d = win_id;
                end
            end
            StReq: state_d = StServ;
            StServ: begin
                if (eret) begin
                    state_d       = StIdle;
                    clr[int_id_q] = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
        // A new edge in the same cycle as the clear wins
        pending_d = (pending_q & ~clr) | irq_edge;
    end

    // State, pending, mask and registered outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= StIdle;
            irq_d_q      <= '0;
            pending_q    <= '0;
            mask_q       <= '1;
            int_id_q     <= '0;
            int_out_q    <= 1'b0;
            in_service_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            irq_d_q      <= irq_s;
            pending_q    <= pending_d;
            int_id_q     <= int_id_d;
            int_out_q    <= (state_d == StReq);
            in_service_q <= (state_d == StServ);
            if (mask_we) mask_q <= mask_wdata;
        end
    end

    assign int_out    = int_out_q;
    assign int_id     = int_id_q;
    assign in_service = in_service_q;
    assign pending    = pending_q;
    assign mask       = mask_q;

endmodule

// File: tb/tb_int_request_ctrl.sv
// Bench for int_request_ctrl: directed test-plan steps followed by random
// traffic, every cycle compared against a transaction-level reference model.
module tb_int_request_ctrl;

    localparam int N = 4;
`ifdef INT_SYNC_EN
    localparam int SL = 2;
`else
    localparam int SL = 0;
`endif

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [N-1:0] irq = '0;
    logic         mask_we = 1'b0;
    logic [N-1:0] mask_wdata = '0;
    logic         eret = 1'b0;
    logic         int_out;
    logic [1:0]   int_id;
    logic         in_service;
    logic [N-1:0] pending;
    logic [N-1:0] mask;

    int total = 0;
    int bad = 0;
    int pulses = 0;

    // Reference model: pending/mask as arrays, one transaction tracked abstractly
    bit           m_pend[N];
    bit           m_mask[N];
    logic [N-1:0] m_prev, m_s1, m_s2;
    bit           m_active, m_first;
    int           m_id;

    int_request_ctrl #(.NSRC(N)) dut (
        .clk       (clk),
        .reset     (reset),
        .irq       (irq),
        .mask_we   (mask_we),
        .mask_wdata(mask_wdata),
        .eret      (eret),
        .int_out   (int_out),
        .int_id    (int_id),
        .in_service(in_service),
        .pending   (pending),
        .mask      (mask)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_pend[i] = 1'b0;
            m_mask[i] = 1'b1;
        end
        m_prev = '0; m_s1 = '0; m_s2 = '0;
        m_active = 1'b0; m_first = 1'b0; m_id = 0;
    endtask

    task automatic model_step();
        logic [N-1:0] seen;
        int win;
        int clr_id;
        seen = (SL != 0) ? m_s2 : irq;
        win = -1;
        for (int i = 0; i < N; i++) if (win < 0 && m_pend[i] && m_mask[i]) win = i;
        clr_id = -1;
        if (!m_active) begin
            if (win >= 0) begin
                m_active = 1'b1; m_first = 1'b1; m_id = win;
            end
        end else if (m_first) begin
            m_first = 1'b0;
        end else if (eret) begin
            m_active = 1'b0; clr_id = m_id;
        end
        for (int i = 0; i < N; i++) begin
            if (i == clr_id) m_pend[i] = 1'b0;
            if (seen[i] && !m_prev[i]) m_pend[i] = 1'b1;
        end
        if (mask_we) for (int i = 0; i < N; i++) m_mask[i] = mask_wdata[i];
        m_prev = seen;
        m_s2 = m_s1;
        m_s1 = irq;
    endtask

    task automatic check_all();
        logic [N-1:0] p, k;
        for (int i = 0; i < N; i++) begin
            p[i] = m_pend[i];
            k[i] = m_mask[i];
        end
        chk("model_int_out", 32'(int_out), 32'(m_active && m_first));
        chk("model_in_service", 32'(in_service), 32'(m_active && !m_first));
        chk("model_int_id", 32'(int_id), 32'(m_id));
        chk("model_pending", 32'(pending), 32'(p));
        chk("model_mask", 32'(mask), 32'(k));
    endtask

    // One clock: model follows the edge, outputs compared at the falling edge
    task automatic cycle();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
        if (int_out) pulses++;
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    int p0;

    initial begin
        model_reset();
        #12;
        chk("rst_int_out", 32'(int_out), 32'd0);
        chk("rst_in_service", 32'(in_service), 32'd0);
        chk("rst_pending", 32'(pending), 32'd0);
        chk("rst_mask", 32'(mask), 32'hf);
        chk("rst_int_id", 32'(int_id), 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Single source
        irq = 4'b0100;
        cycles(1 + SL);
        chk("single_pending", 32'(pending), 32'h4);
        chk("single_idle_out", 32'(int_out), 32'd0);
        cycle();
        chk("single_int_out", 32'(int_out), 32'd1);
        chk("single_int_id", 32'(int_id), 32'd2);
        cycle();
        chk("single_out_drop", 32'(int_out), 32'd0);
        chk("single_serv", 32'(in_service), 32'd1);
        cycles(2);
        chk("single_serv_hold", 32'(in_service), 32'd1);
        eret = 1'b1; cycle(); eret = 1'b0;
        chk("single_done", 32'(in_service), 32'd0);
        chk("single_cleared", 32'(pending), 32'd0);
        irq = '0;
        cycles(3 + SL);

        // Priority
        p0 = pulses;
        irq = 4'b1010;
        cycles(1 + SL);
        chk("prio_pending", 32'(pending), 32'ha);
        cycle();
        chk("prio_first_out", 32'(int_out), 32'd1);
        chk("prio_first_id", 32'(int_id), 32'd1);
        cycle();
        eret = 1'b1; cycle(); eret = 1'b0;
        chk("prio_gap", 32'(int_out), 32'd0);
        cycle();
        chk("prio_second_out", 32'(int_out), 32'd1);
        chk("prio_second_id", 32'(int_id), 32'd3);
        cycle();
        eret = 1'b1; cycle(); eret = 1'b0;
        cycles(3);
        chk("prio_pulses", 32'(pulses - p0), 32'd2);
        irq = '0;
        cycles(2 + SL);

        // Masking
        mask_we = 1'b1; mask_wdata = 4'b1110; cycle(); mask_we = 1'b0;
        chk("mask_written", 32'(mask), 32'he);
        irq = 4'b0001;
        cycles(1 + SL);
        chk("mask_pending", 32'(pending), 32'h1);
        cycles(3);
        chk("mask_no_int", 32'(int_out | in_service), 32'd0);
        mask_we = 1'b1; mask_wdata = 4'b1111; cycle(); mask_we = 1'b0;
        chk("unmask_edge", 32'(int_out), 32'd0);
        cycle();
        chk("unmask_out", 32'(int_out), 32'd1);
        chk("unmask_id", 32'(int_id), 32'd0);
        cycle();
        eret = 1'b1; cycle(); eret = 1'b0;
        irq = '0;
        cycles(2 + SL);

        // Collision: new edge on int_id in the same edge as eret
        irq = 4'b0100;
        cycles(3 + SL);
        chk("coll_serv", 32'(in_service), 32'd1);
        irq = '0;
        cycles(SL + 1);
        irq = 4'b0100;
        cycles(SL);
        eret = 1'b1; cycle(); eret = 1'b0;
        chk("coll_pending", 32'(pending), 32'h4);
        chk("coll_gap", 32'(int_out), 32'd0);
        cycle();
        chk("coll_reissue", 32'(int_out), 32'd1);
        chk("coll_reissue_id", 32'(int_id), 32'd2);
        cycle();
        eret = 1'b1; cycle(); eret = 1'b0;
        irq = '0;
        cycles(2 + SL);

        // Spurious eret in IDLE
        eret = 1'b1; cycle(); eret = 1'b0;
        chk("spur_out", 32'(int_out), 32'd0);
        chk("spur_serv", 32'(in_service), 32'd0);
        chk("spur_pending", 32'(pending), 32'd0);

        // Reset during REQ
        mask_we = 1'b1; mask_wdata = 4'b0011; cycle(); mask_we = 1'b0;
        irq = 4'b0001;
        cycles(2 + SL);
        chk("rreq_out", 32'(int_out), 32'd1);
        #2 reset = 1'b1;
        #1 chk("rreq_async_drop", 32'(int_out), 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        irq = '0;
        model_reset();
        chk("rrel_pending", 32'(pending), 32'd0);
        chk("rrel_mask", 32'(mask), 32'hf);
        chk("rrel_serv", 32'(in_service), 32'd0);
        cycles(2 + SL);

        // Random traffic against the model
        for (int t = 0; t < 500; t++) begin
            irq = N'($urandom);
            mask_we = ($urandom_range(0, 9) == 0);
            mask_wdata = N'($urandom);
            eret = ($urandom_range(0, 2) == 0);
            cycle();
        end
        eret = 1'b0;
        mask_we = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/int_request_ctrl.md
# int_request_ctrl

Interrupt request controller that drives the CPU's single `INT` input and consumes its `eret` indication. It collects rising-edge events from up to NSRC device lines, holds them as pending, masks and prioritizes them, and issues one interrupt at a time. It then waits for the matching `eret` before issuing the next, so the CPU's EPC save/restore is never overrun.

## Interface
- NSRC, 4, number of interrupt sources; legal range 2..16
- IDW, $clog2(NSRC), width of the source ID
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- irq  in  NSRC  device request lines; an event is a 0→1 transition
- mask_we  in  1  write strobe for the mask register
- mask_wdata  in  NSRC  new mask value; bit=1 enables the source
- eret  in  1  one-cycle pulse from the CPU on return from handler
- int_out  out  1  interrupt request to CPU `INT`, registered
- int_id  out  IDW  ID of the source being requested or serviced
- in_service  out  1  high from issue until the accepting `eret`
- pending  out  NSRC  pending event bits, masked or not
- mask  out  NSRC  current mask register

## Operation
- Edge detect:
  - `irq_d` samples `irq` every clk.
  - `edge = irq & ~irq_d`.
  - Each edge bit sets the corresponding `pending` bit.
- Eligible set: `pending & mask`. Priority is fixed; the lowest index wins.
- Masked pending bits stay pending and become eligible when the mask is set.
- FSM states:
  - IDLE: if eligible ≠ 0 → REQ; latch the winner into `int_id`.
  - REQ: `int_out`=1 for exactly this one cycle; → SERV unconditionally.
  - SERV: `in_service`=1; on `eret` → IDLE and clear `pending[int_id]`.
- `eret` in IDLE or REQ is ignored and changes no state.
- Same-bit set and clear in the same cycle (new edge on `int_id` while `eret`): set wins; the bit stays pending and re-issues.
- An edge on a bit already pending is absorbed; there is no count.
- `mask_we` takes effect at the next edge. Masking `int_id` during REQ/SERV does not abort the transaction.
- `int_id` holds its value through SERV and keeps the last value in IDLE.
- Reset values:
  - `int_out`, `in_service`, `pending`, `irq_d`, `int_id` = 0.
  - `mask` = all ones.
  - State = IDLE.
- Reset asserted mid-operation clears everything asynchronously and drops `int_out` immediately. Events in flight are lost.

## Timing
- All state updates occur on the rising clk edge. Reset overrides.
- Worked example, with `irq[k]` driven high before edge E0:
  - E0: `pending[k]`=1.
  - E1: state REQ, `int_id`=k; `int_out` is high in cycle E1–E2.
  - E2: state SERV. The CPU samples `INT` at E2.
- Issue latency from the first sampling edge to `int_out` high is 1 edge (E1); the CPU takes the interrupt at E2.
- `eret` sampled at edge En → IDLE at En. The earliest next `int_out` is high from En+1 (a one-cycle gap), which guarantees the CPU has cleared its EPC.
- Back-to-back interrupt spacing is ≥ 3 cycles: REQ, ≥1 SERV, IDLE.

## Configuration
- `INT_SYNC_EN` defined: each `irq` bit passes through a two-flop synchronizer before edge detect. This adds 2 cycles to issue latency and supports asynchronous device sources.
- Undefined: `irq` feeds edge detect directly. Sources must be synchronous to clk.
- All other behaviour is identical in both builds.

## Test plan
- Single source: `irq[2]` 0→1 before E0. Expect:
  - `pending`=4'b0100 at E0.
  - `int_out`=1 and `int_id`=2 for exactly one cycle after E1.
  - `in_service`=1 until `eret`, after which `pending`=0.
- Priority: `irq[3]` and `irq[1]` rise together. Expect:
  - ID 1 is issued first; after `eret`, ID 3 is issued with `int_out` high exactly one cycle after the IDLE edge.
  - The total is two `int_out` pulses.
- Masking: write mask=4'b1110, then raise `irq[0]`. Expect:
  - `pending[0]`=1 and no `int_out`.
  - After writing mask=4'b1111, `int_out` goes high 1 edge later with `int_id`=0.
- Collision: during SERV of ID 2, re-pulse `irq[2]` on the same edge as `eret`. Expect `pending[2]` to remain 1 and ID 2 to re-issue after the gap cycle.
- Spurious and reset:
  - `eret` while IDLE: no state change.
  - Reset asserted during REQ: `int_out`=0 immediately; `pending`=0 and `mask`=4'b1111 after release.
- Build with `INT_SYNC_EN`: repeat the single-source test. Expect `int_out` 2 cycles later than the unsynchronized build.
